rng_word_splitter: RTL
======================

Name: rng_word_splitter

Overview:
- Consumer stage directly downstream of the AES-CTR DRBG.
- Pulls 128-bit random words through the DRBG's update/ready/randombits interface and re-emits them as OUT_W-bit chunks on a valid/ready stream. The signature datapath uses these chunks for field-element and salt sampling.
- Holds one prefetched word so that OUT_W<=64 sustains one chunk per cycle.
- Forwards the DRBG reseed-exhaustion flag and stops fetching when it is set.

Parameters:
- OUT_W, 32, output chunk width; legal values 8, 16, 32, 64, 128 (must divide 128).
- CHUNKS, 128/OUT_W, derived (localparam); chunks per DRBG word.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- drbg_ready  in  1  DRBG has at least one word queued.
- drbg_update  out  1  pop request to DRBG; DRBG's randombits is valid the cycle after a cycle with drbg_update&&drbg_ready.
- drbg_randombits  in  128  DRBG output word register.
- drbg_shouldreset  in  1  DRBG reseed counter exhausted.
- flush  in  1  discard all buffered and in-flight random bits.
- out_valid  out  1  out_data holds a fresh chunk.
- out_ready  in  1  consumer accepts chunk.
- out_data  out  OUT_W  random chunk.
- reseed_req  out  1  registered copy of drbg_shouldreset.
- chunk_count  out  32  number of chunks delivered; saturates at 0xFFFF_FFFF.

Behaviour:
- Storage:
  - sr[127:0], shift register; cnt[log2(CHUNKS):0], chunks left in sr.
  - pf[127:0] with pf_valid, prefetch word.
  - pending, 1 = word requested, capture due this cycle.
  - drop, 1 = pending capture to be discarded.
- Reset: sr=0, cnt=0, pf=0, pf_valid=0, pending=0, drop=0, chunk_count=0, reseed_req=0.
  - Outputs during and after reset: out_valid=0, out_data=0, drbg_update=0.
- Output stage:
  - out_valid = (cnt!=0); out_data = sr[OUT_W-1:0], LSB chunk first.
  - fire = out_valid && out_ready.
  - On fire: sr <= sr>>OUT_W (zero-fill), cnt <= cnt-1, chunk_count += 1 unless saturated.
- Load:
  - pf_load = pf_valid && (cnt==0 || (cnt==1 && fire)).
  - On pf_load: sr <= pf, cnt <= CHUNKS, pf_valid <= 0. pf_load takes priority over the fire decrement.
- Fetch (drbg_update is combinational):
  - drbg_update = drbg_ready && !pending && !drbg_shouldreset && !flush && (!pf_valid || pf_load).
  - A cycle with drbg_update=1 sets pending=1 for exactly the next cycle.
  - In that pending cycle: pf <= drbg_randombits and pf_valid <= 1, unless drop or flush, in which case the word is discarded. pending <= 0.
  - Never issue drbg_update while pending=1; at most one word is in flight.
- Throughput:
  - First out_valid appears 3 cycles after the first drbg_update (update, capture, load).
  - Continuous out_valid when out_ready=1 and drbg_ready=1, for OUT_W<=64.
  - OUT_W=128 delivers one chunk every 2 cycles.
- Flush (single-cycle or held):
  - Next cycle: cnt=0, pf_valid=0, out_valid=0.
  - If pending=1 in the flush cycle, the arriving word is discarded.
  - A fire coexisting with flush still counts in chunk_count; flush has priority over pf_load.
  - No drbg_update is issued while flush=1.
- Reseed:
  - reseed_req <= drbg_shouldreset every cycle.
  - While drbg_shouldreset=1, no new fetches are issued. Buffered chunks (sr, pf, any pending word) still drain normally, and out_valid drops to 0 once they are exhausted.
- Empty DRBG (drbg_ready=0): no update; the output drains, then out_valid=0 with no spurious chunk.
- Backpressure: out_ready=0 holds sr, cnt and out_data stable. pf stays filled, and fetching stops after pf is full.
- Reset asserted mid-operation: all state returns to reset values on that edge, and any pending word is lost. The DRBG retains its own queue.

Test Plan:
- Startup, OUT_W=32: DRBG model returns 0x0F0E..0100 (byte i = i), drbg_ready=1, out_ready=1.
  - drbg_update at cycle 0; out_valid first at cycle 3.
  - out_data = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles.
- Sustained stream, OUT_W=64: 16 sequential words, out_ready=1.
  - 32 chunks with no out_valid gaps after the first; chunk_count=32.
  - Exactly 16 drbg_update pulses; never 2 consecutive.
- Backpressure: out_ready=0 for 10 cycles mid-word.
  - out_data stable; exactly one extra word fetched (pf full), then drbg_update=0 until out_ready=1.
- Flush with pending=1:
  - Next cycle out_valid=0; the captured word never appears on out_data.
  - Next chunk comes from the following DRBG word.
- Reseed: drbg_shouldreset=1 with sr holding 2 chunks and pf full.
  - reseed_req=1 next cycle; 2+CHUNKS chunks drain, then out_valid=0; no drbg_update while shouldreset=1.
- Reset mid-stream (rst_n=0 one cycle with cnt=3, pf_valid=1):
  - Next cycle: out_valid=0, chunk_count=0, drbg_update=0 during reset.
  - Normal 3-cycle restart after release.

Source files
------------

// File: rtl/rng_word_splitter.sv
// Splits 128-bit DRBG words into OUT_W-bit chunks on a valid/ready stream,
// keeping one prefetched word so OUT_W<=64 can stream one chunk per cycle.
module rng_word_splitter #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             drbg_ready,
    output logic             drbg_update,
    input  logic [127:0]     drbg_randombits,
    input  logic             drbg_shouldreset,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             reseed_req,
    output logic [31:0]      chunk_count
);

    localparam int CHUNKS = 128 / OUT_W;
    localparam int CW     = $clog2(CHUNKS) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CHUNKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [127:0]  sr;
    logic [127:0]  pf;
    logic [CW-1:0] cnt;
    logic          pf_valid;
    logic          pending;
    logic          drop;
    logic          fire;
    logic          pf_load;

    // Outputs are gated by rst_n so they read zero during the reset cycle itself.
    always_comb begin
        out_valid   = rst_n && (cnt != '0);
        out_data    = rst_n ? sr[OUT_W-1:0] : '0;
        fire        = out_valid && out_ready;
        pf_load     = pf_valid && ((cnt == '0) || ((cnt == CNT_ONE) && fire));
        drbg_update = rst_n && drbg_ready && !pending && !drbg_shouldreset && !flush
                      && (!pf_valid || pf_load);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr          <= '0;
            pf          <= '0;
            cnt         <= '0;
            pf_valid    <= 1'b0;
            pending     <= 1'b0;
            drop        <= 1'b0;
            chunk_count <= '0;
            reseed_req  <= 1'b0;
        end else begin
            reseed_req <= drbg_shouldreset;
            pending    <= drbg_update;
            drop       <= drbg_update && flush;

            if (fire && (chunk_count != '1))
                chunk_count <= chunk_count + 32'd1;

            if (flush) begin
                sr       <= '0;
                cnt      <= '0;
                pf_valid <= 1'b0;
            end else if (pf_load) begin
                sr       <= pf;
                cnt      <= CNT_FULL;
                pf_valid <= 1'b0;
            end else if (fire) begin
                sr  <= sr >> OUT_W;
                cnt <= cnt - CNT_ONE;
            end

            // The pending word lands after any load, so the fresh prefetch survives.
            if (pending && !(drop || flush)) begin
                pf       <= drbg_randombits;
                pf_valid <= 1'b1;
            end
        end
    end

endmodule
